// File: rtl/pixel_pingpong_ram.sv
`default_nettype none
// ============================================================================
// Module   : pixel_pingpong_ram
// Purpose  : Double-buffered pixel store. A streaming writer fills the back
//            bank while a random-access reader scans the front bank. Banks
//            swap only at frame boundaries, gated by a reader release.
//            Optional macro PIXEL_PINGPONG_DROP_EN: discard (and count)
//            pixels offered while a swap is pending instead of stalling.
// Revision : 1.0 - initial release
// ============================================================================
module pixel_pingpong_ram #(
  parameter int DATA_WIDTH   = 24,
  parameter int ADDR_WIDTH   = 9,
  parameter int FRAME_LENGTH = 2**ADDR_WIDTH
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic [DATA_WIDTH-1:0] wr_data,
  input  logic                  wr_valid,
  input  logic                  wr_sof,
  output logic                  wr_ready,
  input  logic [ADDR_WIDTH-1:0] rd_addr,
  input  logic                  rd_en,
  output logic [DATA_WIDTH-1:0] rd_data,
  input  logic                  rd_release,
  output logic                  rd_frame_valid,
  output logic                  rd_bank,
  output logic [7:0]            frame_count,
  output logic [15:0]           drop_count
);

  localparam int                    c_DEPTH = 2**ADDR_WIDTH;
  localparam logic [ADDR_WIDTH-1:0] c_LAST  = ADDR_WIDTH'(FRAME_LENGTH - 1);

  typedef enum logic [1:0] {
    ST_EMPTY   = 2'd0,
    ST_SHOWING = 2'd1,
    ST_PENDING = 2'd2
  } state_t;

  logic [DATA_WIDTH-1:0] r_mem [0:2*c_DEPTH-1];

  state_t                r_state;
  state_t                w_state_next;
  logic                  r_armed;
  logic                  w_armed_next;
  logic                  w_swap;
  logic                  r_wr_bank;
  logic                  r_rd_bank;
  logic                  r_frame_valid;
  logic [7:0]            r_frame_count;
  logic [DATA_WIDTH-1:0] r_rd_data;
  logic [ADDR_WIDTH-1:0] r_wr_ptr;
  logic [ADDR_WIDTH-1:0] w_wr_addr;
  logic [ADDR_WIDTH-1:0] w_ptr_next;
  logic                  w_wr_open;
  logic                  w_accept;
  logic                  w_complete;

  assign w_wr_open  = (r_state != ST_PENDING);
  assign w_accept   = wr_valid && w_wr_open;
  assign w_wr_addr  = wr_sof ? '0 : r_wr_ptr;
  assign w_complete = w_accept && (w_wr_addr == c_LAST);
  assign w_ptr_next = w_complete ? '0 : w_wr_addr + ADDR_WIDTH'(1);

  // Pixel store: no reset, contents survive reset but are only trusted after a swap
  always_ff @(posedge clk) begin
    if (w_accept) begin
      r_mem[{r_wr_bank, w_wr_addr}] <= wr_data;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_wr_ptr <= '0;
    end else if (w_accept) begin
      r_wr_ptr <= w_ptr_next;
`ifdef PIXEL_PINGPONG_DROP_EN
    end else if (wr_valid && wr_sof) begin
      r_wr_ptr <= '0;
`endif
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_rd_data <= '0;
    end else if (rd_en) begin
      r_rd_data <= r_mem[{r_rd_bank, rd_addr}];
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state       <= ST_EMPTY;
      r_armed       <= 1'b0;
      r_wr_bank     <= 1'b0;
      r_rd_bank     <= 1'b1;
      r_frame_valid <= 1'b0;
      r_frame_count <= 8'd0;
    end else begin
      r_state <= w_state_next;
      r_armed <= w_armed_next;
      if (w_swap) begin
        r_wr_bank     <= ~r_wr_bank;
        r_rd_bank     <= ~r_rd_bank;
        r_frame_valid <= 1'b1;
        r_frame_count <= r_frame_count + 8'd1;
      end
    end
  end

  always_comb begin
    w_state_next = r_state;
    w_armed_next = r_armed;
    w_swap       = 1'b0;
    case (r_state)
      ST_EMPTY: begin
        if (w_complete) begin
          w_swap       = 1'b1;
          w_state_next = ST_SHOWING;
        end
      end
      ST_SHOWING: begin
        if (w_complete) begin
          if (r_armed || rd_release) begin
            w_swap       = 1'b1;
            w_armed_next = 1'b0;
          end else begin
            w_state_next = ST_PENDING;
          end
        end else if (rd_release) begin
          w_armed_next = 1'b1;
        end
      end
      ST_PENDING: begin
        if (rd_release) begin
          w_swap       = 1'b1;
          w_state_next = ST_SHOWING;
        end
      end
      default: w_state_next = ST_EMPTY;
    endcase
  end

`ifdef PIXEL_PINGPONG_DROP_EN
  logic [15:0] r_drop_count;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_drop_count <= 16'd0;
    end else if (wr_valid && !w_wr_open && (r_drop_count != 16'hFFFF)) begin
      r_drop_count <= r_drop_count + 16'd1;
    end
  end

  assign wr_ready   = 1'b1;
  assign drop_count = r_drop_count;
`else
  assign wr_ready   = w_wr_open;
  assign drop_count = 16'd0;
`endif

  assign rd_data        = r_rd_data;
  assign rd_frame_valid = r_frame_valid;
  assign rd_bank        = r_rd_bank;
  assign frame_count    = r_frame_count;

endmodule
`default_nettype wire

// File: tb/tb_pixel_pingpong_ram.sv
`default_nettype none
// ============================================================================
// Module   : tb_pixel_pingpong_ram
// Purpose  : Self-checking bench for pixel_pingpong_ram against a frame-level
//            reference model (directed frames followed by random traffic).
// Revision : 1.0 - initial release
// ============================================================================
module tb_pixel_pingpong_ram;

  localparam int DW = 24;
  localparam int AW = 4;
  localparam int FL = 16;

  logic          clk = 1'b0;
  logic          reset_n = 1'b0;
  logic [DW-1:0] wr_data = '0;
  logic          wr_valid = 1'b0;
  logic          wr_sof = 1'b0;
  logic          wr_ready;
  logic [AW-1:0] rd_addr = '0;
  logic          rd_en = 1'b0;
  logic [DW-1:0] rd_data;
  logic          rd_release = 1'b0;
  logic          rd_frame_valid;
  logic          rd_bank;
  logic [7:0]    frame_count;
  logic [15:0]   drop_count;

  int n_checks = 0;
  int n_errors = 0;

  pixel_pingpong_ram #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .FRAME_LENGTH(FL)) dut (
    .clk(clk), .reset_n(reset_n),
    .wr_data(wr_data), .wr_valid(wr_valid), .wr_sof(wr_sof), .wr_ready(wr_ready),
    .rd_addr(rd_addr), .rd_en(rd_en), .rd_data(rd_data), .rd_release(rd_release),
    .rd_frame_valid(rd_frame_valid), .rd_bank(rd_bank),
    .frame_count(frame_count), .drop_count(drop_count)
  );

  always #5 clk = ~clk;

  // Reference model: two banks of pixels plus flags describing the frame handoff
  logic [DW-1:0] m_mem [0:2*FL-1];
  bit            m_front;
  int            m_ptr;
  bit            m_pending;
  bit            m_armed;
  bit            m_have_frame;
  logic [7:0]    m_fc;
  int            m_drop;
  logic [DW-1:0] m_rd;
  bit            chk_en = 1'b0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_front = 1'b1; m_ptr = 0; m_pending = 0; m_armed = 0;
    m_have_frame = 0; m_fc = 8'd0; m_drop = 0; m_rd = '0;
  endtask

  task automatic model_swap();
    m_front      = !m_front;
    m_fc         = m_fc + 8'd1;
    m_have_frame = 1;
  endtask

  task automatic model_step();
    bit accept, done;
    int a;
    done   = 0;
    accept = wr_valid && !m_pending;
    if (rd_en) m_rd = m_mem[int'(m_front) * FL + int'(rd_addr)];
    if (accept) begin
      a = wr_sof ? 0 : m_ptr;
      m_mem[int'(!m_front) * FL + a] = wr_data;
      if (a == FL - 1) begin
        done  = 1;
        m_ptr = 0;
      end else begin
        m_ptr = a + 1;
      end
    end
`ifdef PIXEL_PINGPONG_DROP_EN
    if (wr_valid && m_pending) begin
      if (wr_sof) m_ptr = 0;
      if (m_drop < 65535) m_drop++;
    end
`endif
    if (done) begin
      if (!m_have_frame) model_swap();
      else if (m_armed || rd_release) begin
        model_swap();
        m_armed = 0;
      end else m_pending = 1;
    end else if (rd_release) begin
      if (m_pending) begin
        model_swap();
        m_pending = 0;
      end else if (m_have_frame) m_armed = 1;
    end
  endtask

  always @(negedge clk) begin
    if (chk_en && reset_n) begin
      chk("rd_data", 32'(rd_data), 32'(m_rd));
      chk("rd_bank", 32'(rd_bank), 32'(m_front));
      chk("frame_count", 32'(frame_count), 32'(m_fc));
      chk("rd_frame_valid", 32'(rd_frame_valid), 32'(m_have_frame));
`ifdef PIXEL_PINGPONG_DROP_EN
      chk("wr_ready", 32'(wr_ready), 32'd1);
`else
      chk("wr_ready", 32'(wr_ready), 32'(!m_pending));
`endif
      chk("drop_count", 32'(drop_count), 32'(m_drop));
    end
  end

  task automatic tick();
    @(posedge clk);
    model_step();
    @(negedge clk);
  endtask

  task automatic px(input logic [DW-1:0] d, input bit sof, input bit rel);
    wr_valid = 1'b1; wr_data = d; wr_sof = sof; rd_release = rel;
    tick();
    wr_valid = 1'b0; wr_sof = 1'b0; rd_release = 1'b0;
  endtask

  task automatic rd(input int addr);
    rd_addr = AW'(addr); rd_en = 1'b1;
    tick();
    rd_en = 1'b0;
  endtask

  task automatic release_pulse();
    rd_release = 1'b1;
    tick();
    rd_release = 1'b0;
  endtask

  task automatic reset_literals(input string tag);
    chk({tag, "_frame_valid"}, 32'(rd_frame_valid), 32'd0);
    chk({tag, "_rd_bank"}, 32'(rd_bank), 32'd1);
    chk({tag, "_wr_ready"}, 32'(wr_ready), 32'd1);
    chk({tag, "_frame_count"}, 32'(frame_count), 32'd0);
    chk({tag, "_rd_data"}, 32'(rd_data), 32'd0);
    chk({tag, "_drop_count"}, 32'(drop_count), 32'd0);
  endtask

  initial begin
    model_reset();
    repeat (3) @(negedge clk);
    reset_literals("reset");
    reset_n = 1'b1;
    chk_en  = 1'b1;

    for (int i = 0; i < FL; i++) px(DW'(i), i == 0, 1'b0);
    chk("first_swap_bank", 32'(rd_bank), 32'd0);
    chk("first_swap_count", 32'(frame_count), 32'd1);
    rd(5);
    chk("first_read", 32'(rd_data), 32'h000005);

    for (int i = 0; i < FL; i++) px(DW'(32'h100000 + i), i == 0, 1'b0);
`ifndef PIXEL_PINGPONG_DROP_EN
    chk("pending_ready", 32'(wr_ready), 32'd0);
`endif
    rd(3);
    chk("pending_front_read", 32'(rd_data), 32'h000003);
    release_pulse();
    chk("release_bank", 32'(rd_bank), 32'd1);
    chk("release_count", 32'(frame_count), 32'd2);
    rd(3);
    chk("release_read", 32'(rd_data), 32'h100003);

    for (int i = 0; i < FL; i++) px(DW'(32'h200000 + i), i == 0, i == 8);
    chk("armed_swap_count", 32'(frame_count), 32'd3);
    chk("armed_swap_ready", 32'(wr_ready), 32'd1);

    for (int i = 0; i < 7; i++) px(DW'(32'hAA0000 + i), i == 0, 1'b0);
    for (int i = 0; i < FL; i++) px(DW'(32'hBB0000 + i), i == 0, 1'b0);
    chk("restart_no_swap", 32'(frame_count), 32'd3);
    release_pulse();
    chk("restart_swap", 32'(frame_count), 32'd4);
    rd(2);
    chk("restart_read", 32'(rd_data), 32'hBB0002);

    for (int i = 0; i < FL; i++) px(DW'(32'hCC0000 + i), i == 0, 1'b0);
`ifdef PIXEL_PINGPONG_DROP_EN
    for (int i = 0; i < 3; i++) px(DW'(32'hDD0000 + i), i == 1, 1'b0);
    chk("drop_count3", 32'(drop_count), 32'd3);
    chk("drop_ready", 32'(wr_ready), 32'd1);
    rd(2);
    chk("drop_front_read", 32'(rd_data), 32'hBB0002);
`endif

    @(posedge clk);
    #2 reset_n = 1'b0;
    #1 reset_literals("async_reset");
    model_reset();
    @(negedge clk);
    reset_n = 1'b1;

    for (int c = 0; c < 3000; c++) begin
      wr_valid   = ($urandom % 4) != 0;
      wr_sof     = ($urandom % 24) == 0;
      wr_data    = DW'($urandom);
      rd_en      = ($urandom % 2) == 1;
      rd_addr    = AW'($urandom);
      rd_release = ($urandom % 20) == 0;
      tick();
    end
    wr_valid = 1'b0; rd_en = 1'b0; rd_release = 1'b0; wr_sof = 1'b0;
    tick();

    chk_en = 1'b0;
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire
